// File: rtl/inst_rom_srv.sv
// Instruction store answering core fetches after WAIT_STATES wait cycles (stall raised until ready),
// with a big-endian byte-stream loader that fills the store from word 0 and holds fetch off while busy.
module inst_rom_srv #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce,
  input  logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        rom_stallreq,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_busy,
  output logic        load_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, HIT} state_t;

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [31:0]         srv_addr;
  logic                srv_valid;
  logic [31:0]         data_q;
  logic [1:0]          cnt;

  logic [DEPTH_LOG2:0] wp;
  logic [1:0]          lane;
  logic [31:0]         word_buf;

  logic                in_range;
  logic [31:0]         rom_word;
  logic                hit;
  logic                restart;

  assign in_range = (rom_addr[31:DEPTH_LOG2+2] == '0) && (rom_addr[1:0] == 2'b00);
  assign rom_word = in_range ? mem[rom_addr[DEPTH_LOG2+1:2]] : 32'h0;
  assign hit      = srv_valid && (rom_addr == srv_addr);
  // A miss restarts the count unless we are already waiting on this very address.
  assign restart  = rom_ce && !load_busy && !hit && !((state == WAIT) && (rom_addr == srv_addr));

  always_comb begin
    rom_data     = 32'h0;
    rom_stallreq = 1'b0;
    if (!rst && rom_ce) begin
      if (!load_busy && hit) rom_data = data_q;
      else                   rom_stallreq = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      srv_addr  <= 32'h0;
      srv_valid <= 1'b0;
      data_q    <= 32'h0;
      cnt       <= 2'd0;
    end else begin
      if (!rom_ce || load_busy) begin
        state <= IDLE;
      end else if (hit) begin
        state <= HIT;
      end else if (restart) begin
        srv_addr  <= rom_addr;
        srv_valid <= 1'b0;
        if (WAIT_STATES == 0) begin
          data_q    <= rom_word;
          srv_valid <= 1'b1;
          state     <= HIT;
        end else begin
          cnt   <= 2'(WAIT_STATES - 1);
          state <= WAIT;
        end
      end else begin
        if (cnt == 2'd0) begin
          data_q    <= rom_word;
          srv_valid <= 1'b1;
          state     <= HIT;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
      if (load_start) srv_valid <= 1'b0;
    end
  end

  logic                accept;
  logic [DEPTH_LOG2:0] eff_wp;
  logic [1:0]          eff_lane;
  logic [31:0]         new_word;
  logic                full;
  logic                word_done;

  // A load_start in the same cycle as a byte makes that byte lane 0 of the new session.
  assign accept    = load_valid && (load_busy || load_start);
  assign eff_wp    = load_start ? '0 : wp;
  assign eff_lane  = load_start ? 2'd0 : lane;
  assign new_word  = (load_start ? 32'h0 : word_buf) | ({load_byte, 24'h0} >> {eff_lane, 3'b000});
  assign full      = eff_wp[DEPTH_LOG2];
  assign word_done = (eff_lane == 2'd3) || load_last;

  always_ff @(posedge clk) begin
    if (!rst && accept && !full && word_done) mem[eff_wp[DEPTH_LOG2-1:0]] <= new_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_busy <= 1'b0;
      load_err  <= 1'b0;
      wp        <= '0;
      lane      <= 2'd0;
      word_buf  <= 32'h0;
    end else begin
      if (load_start) begin
        load_busy <= 1'b1;
        load_err  <= 1'b0;
        wp        <= '0;
        lane      <= 2'd0;
        word_buf  <= 32'h0;
      end
      if (accept) begin
        if (full) begin
          load_err <= 1'b1;
        end else if (word_done) begin
          wp       <= eff_wp + 1'b1;
          lane     <= 2'd0;
          word_buf <= 32'h0;
        end else begin
          lane     <= eff_lane + 2'd1;
          word_buf <= new_word;
        end
        if (load_last) load_busy <= 1'b0;
      end
    end
  end

  assign load_ready = load_busy;

endmodule

// File: tb/tb_inst_rom_srv.sv
// Drives two instances (10-bit depth / 1 wait state, 2-bit depth / 3 wait states) from shared inputs
// and checks both against a byte-count/streak reference model plus hand-computed expectations.
module tb_inst_rom_srv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rom_ce, load_start, load_valid, load_last;
  logic [31:0] rom_addr;
  logic [7:0]  load_byte;
  logic [31:0] rd_o [2];
  logic        st_o [2], rdy_o [2], busy_o [2], err_o [2];

  inst_rom_srv #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rd_o[0]),
    .rom_stallreq(st_o[0]), .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(rdy_o[0]), .load_busy(busy_o[0]), .load_err(err_o[0]));

  inst_rom_srv #(.DEPTH_LOG2(2), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rd_o[1]),
    .rom_stallreq(st_o[1]), .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(rdy_o[1]), .load_busy(busy_o[1]), .load_err(err_o[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: words by byte count, fetch readiness by how long one address has been held.
  int          depth [2] = '{1024, 4};
  int          ws    [2] = '{1, 3};
  bit [31:0]   mmem   [2][1024];
  bit          mknown [2][1024];
  bit          m_busy [2], m_err [2], s_ok [2], s_known [2];
  logic [31:0] s_addr [2], s_data [2], k_addr [2];
  int          streak [2], nbytes [2];
  bit [31:0]   cur [2];
  bit          cmp_en = 1'b0;

  function automatic bit in_rng(int k, logic [31:0] a);
    return (a[1:0] == 2'b00) && (int'(a >> 2) < depth[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_err[k] = 0; s_ok[k] = 0; streak[k] = 0;
      end else begin
        if (rom_ce && !m_busy[k]) begin
          if (!(s_ok[k] && rom_addr == s_addr[k])) begin
            s_ok[k] = 0;
            if (streak[k] > 0 && rom_addr == k_addr[k]) streak[k]++;
            else begin k_addr[k] = rom_addr; streak[k] = 1; end
            if (streak[k] == ws[k] + 1) begin
              s_ok[k] = 1; s_addr[k] = rom_addr; streak[k] = 0;
              s_data[k]  = in_rng(k, rom_addr) ? mmem[k][int'(rom_addr >> 2)] : 32'h0;
              s_known[k] = in_rng(k, rom_addr) ? mknown[k][int'(rom_addr >> 2)] : 1'b1;
            end
          end
        end else begin
          streak[k] = 0;
        end
        if (load_start) begin
          m_busy[k] = 1; m_err[k] = 0; nbytes[k] = 0; cur[k] = 0; s_ok[k] = 0;
        end
        if (load_valid && m_busy[k]) begin
          if (nbytes[k] >= 4 * depth[k]) begin
            m_err[k] = 1;
          end else begin
            cur[k][31 - 8 * (nbytes[k] % 4) -: 8] = load_byte;
            if (nbytes[k] % 4 == 3 || load_last) begin
              mmem[k][nbytes[k] / 4] = cur[k]; mknown[k][nbytes[k] / 4] = 1; cur[k] = 0;
            end
          end
          nbytes[k]++;
          if (load_last) m_busy[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] ed;
        logic        es;
        bit          dknown;
        ed = 32'h0; es = 1'b0; dknown = 1'b1;
        if (!rst && rom_ce) begin
          if (!m_busy[k] && s_ok[k] && rom_addr == s_addr[k]) begin ed = s_data[k]; dknown = s_known[k]; end
          else es = 1'b1;
        end
        chk($sformatf("u%0d stallreq", k), 32'(st_o[k]), 32'(es));
        if (dknown) chk($sformatf("u%0d rom_data", k), rd_o[k], ed);
        chk($sformatf("u%0d load_busy", k), 32'(busy_o[k]), 32'(m_busy[k]));
        chk($sformatf("u%0d load_ready", k), 32'(rdy_o[k]), 32'(m_busy[k]));
        chk($sformatf("u%0d load_err", k), 32'(err_o[k]), 32'(m_err[k]));
      end
    end
  end

  logic [7:0]  bytes_q [$];
  bit          ce_noise = 1'b0;
  logic [31:0] atab [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h3C, 32'h40, 32'h1000, 32'h2, 32'h80000000};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic noise();
    if (ce_noise) begin
      rom_ce = 1'($urandom_range(0, 1));
      rom_addr = atab[$urandom_range(0, 9)];
    end else begin
      rom_ce = 1'b0;
    end
  endtask

  task automatic do_load(input bit same_cycle, input bit gaps);
    if (!same_cycle) begin load_start = 1'b1; noise(); step(); load_start = 1'b0; end
    for (int i = 0; i < bytes_q.size(); i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin load_valid = 1'b0; noise(); step(); end
      load_valid = 1'b1; load_byte = bytes_q[i]; load_last = (i == bytes_q.size() - 1);
      load_start = same_cycle && (i == 0);
      noise(); step();
    end
    load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0; rom_ce = 1'b0;
    step();
  endtask

  task automatic fetch(input logic [31:0] a, output int s0, output int s1, output logic [31:0] d0,
                       output logic [31:0] d1);
    bit done0, done1;
    done0 = 0; done1 = 0; s0 = 0; s1 = 0; d0 = 'x; d1 = 'x;
    rom_ce = 1'b1; rom_addr = a;
    for (int c = 0; c < 20 && !(done0 && done1); c++) begin
      @(negedge clk);
      if (!done0) begin if (st_o[0]) s0++; else begin done0 = 1; d0 = rd_o[0]; end end
      if (!done1) begin if (st_o[1]) s1++; else begin done1 = 1; d1 = rd_o[1]; end end
      @(posedge clk); #1;
    end
    chk("fetch completes u0", 32'(done0), 32'd1);
    chk("fetch completes u1", 32'(done1), 32'd1);
  endtask

  initial begin
    int s0, s1;
    logic [31:0] d0, d1;
    rst = 1'b1; rom_ce = 1'b0; rom_addr = 32'h0;
    load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
    step();
    cmp_en = 1'b1;
    step(); step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset rom_data", rd_o[k], 32'h0);
      chk("reset stallreq", 32'(st_o[k]), 32'd0);
      chk("reset load_busy", 32'(busy_o[k]), 32'd0);
      chk("reset load_err", 32'(err_o[k]), 32'd0);
      chk("reset load_ready", 32'(rdy_o[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    bytes_q = '{8'h34, 8'h01, 8'h00, 8'h0A, 8'h24, 8'h02};
    do_load(1'b0, 1'b0);
    chk("busy low after load", 32'(busy_o[0]), 32'd0);
    fetch(32'h0, s0, s1, d0, d1);
    chk("ws1 stall cycles", 32'(s0), 32'd2);
    chk("ws1 word0", d0, 32'h3401000A);
    chk("ws3 stall cycles", 32'(s1), 32'd4);
    chk("ws3 word0", d1, 32'h3401000A);
    fetch(32'h4, s0, s1, d0, d1);
    chk("word1 padded u0", d0, 32'h24020000);
    chk("word1 padded u1", d1, 32'h24020000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("repeat no stall", 32'(st_o[0]), 32'd0);
      chk("repeat data stable", rd_o[0], 32'h24020000);
      @(posedge clk); #1;
    end

    rom_addr = 32'h0; step(); step();
    fetch(32'h4, s0, s1, d0, d1);
    chk("midwait restart stalls u1", 32'(s1), 32'd4);
    chk("midwait data u1", d1, 32'h24020000);
    chk("midwait restart stalls u0", 32'(s0), 32'd2);

    fetch(32'h1000, s0, s1, d0, d1);
    chk("out of range stalls", 32'(s0), 32'd2);
    chk("out of range data", d0, 32'h0);
    fetch(32'h2, s0, s1, d0, d1);
    chk("misaligned data u0", d0, 32'h0);
    chk("misaligned data u1", d1, 32'h0);

    rom_ce = 1'b0; rom_addr = 32'h4;
    @(negedge clk);
    chk("ce off data", rd_o[0], 32'h0);
    chk("ce off stall", 32'(st_o[1]), 32'd0);
    @(posedge clk); #1;

    bytes_q = {};
    for (int i = 0; i < 20; i++) bytes_q.push_back(8'(8'h10 + i));
    do_load(1'b1, 1'b1);
    chk("overflow err u1", 32'(err_o[1]), 32'd1);
    chk("no overflow u0", 32'(err_o[0]), 32'd0);
    fetch(32'hC, s0, s1, d0, d1);
    chk("word3 u1", d1, 32'h1C1D1E1F);
    chk("word3 u0", d0, 32'h1C1D1E1F);
    fetch(32'h10, s0, s1, d0, d1);
    chk("word4 u0", d0, 32'h20212223);
    chk("word4 u1 out of range", d1, 32'h0);

    rom_ce = 1'b0; load_start = 1'b1; step(); load_start = 1'b0;
    @(negedge clk);
    chk("start clears err", 32'(err_o[1]), 32'd0);
    chk("start sets busy", 32'(busy_o[1]), 32'd1);
    @(posedge clk); #1;
    bytes_q = '{8'hAB};
    do_load(1'b1, 1'b0);
    fetch(32'h0, s0, s1, d0, d1);
    chk("single byte word u0", d0, 32'hAB000000);

    rom_addr = 32'h8; rom_ce = 1'b1; step();
    rst = 1'b1; step(); rst = 1'b0; rom_ce = 1'b0;
    @(negedge clk);
    chk("rst in wait stall", 32'(st_o[1]), 32'd0);
    chk("rst in wait data", rd_o[1], 32'h0);
    @(posedge clk); #1;
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_byte = 8'h55; step(); step();
    load_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("rst mid load busy", 32'(busy_o[0]), 32'd0);
    chk("rst mid load ready", 32'(rdy_o[0]), 32'd0);
    @(posedge clk); #1;
    fetch(32'h0, s0, s1, d0, d1);
    chk("written word kept", d0, 32'hAB000000);

    bytes_q = {};
    for (int i = 0; i < 64; i++) bytes_q.push_back(8'($urandom));
    do_load(1'b1, 1'b0);
    for (int ep = 0; ep < 300; ep++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        bytes_q = {};
        for (int i = 0; i < $urandom_range(1, 24); i++) bytes_q.push_back(8'($urandom));
        ce_noise = 1'b1;
        do_load(1'($urandom_range(0, 1)), 1'b1);
        ce_noise = 1'b0;
      end else if (kind == 1) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else begin
        for (int c = 0; c < $urandom_range(1, 8); c++) begin
          rom_ce = ($urandom_range(0, 4) != 0);
          if ($urandom_range(0, 9) < 4) rom_addr = atab[$urandom_range(0, 9)];
          step();
        end
      end
    end

    rom_ce = 1'b0; step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
